// File: rtl/xor_cipher_sequencer.sv
// Sequencer for the XOR cipher datapath: clear, encrypt and copy-out passes.
// Owns the RAM address counter and edge-detects its command inputs.
module xor_cipher_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int N_SRC  = 3,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              crypt,
    input  logic [N_SRC-1:0]  btn,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr,
    output logic              ram_we,
    output logic              clr_ram,
    output logic              en_encryption,
    output logic              en_copier,
    output logic [SEL_W-1:0]  src_sel,
    output logic              busy,
    output logic              done,
    output logic              led_init,
    output logic              led_wait
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ENCRYPT = 3'd2,
        S_WAIT    = 3'd3,
        S_COPY    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [SEL_W-1:0]  CIPHER = SEL_W'(N_SRC - 1);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    state_t             state;
    state_t             state_n;
    logic               crypt_q;
    logic [N_SRC-1:0]   btn_q;

    logic               crypt_rise;
    logic [N_SRC-1:0]   btn_rise;
    logic               btn_valid;
    logic [SEL_W-1:0]   btn_idx;

    logic [ADDR_W-1:0]  addr_n;
    logic [SEL_W-1:0]   sel_n;
    logic               done_n;
    logic               last;

    logic               we_n;
    logic               clr_n;
    logic               enc_n;
    logic               cop_n;
    logic               busy_n;
    logic               init_n;
    logic               wait_n;

    assign crypt_rise = crypt & ~crypt_q;
    assign btn_rise   = btn & ~btn_q;
    assign btn_valid  = $onehot(btn_rise);
    assign last       = (addr == LAST);

    // Index of the single rising button (only used when btn_valid).
    always_comb begin
        btn_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (btn_rise[i]) begin
                btn_idx = SEL_W'(i);
            end
        end
    end

    // Next state, next address counter, source select and done pulse.
    always_comb begin
        state_n = state;
        addr_n  = '0;
        sel_n   = src_sel;
        done_n  = 1'b0;
        case (state)
            S_INIT: begin
                if (crypt_rise) begin
                    state_n = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_n = S_INIT;
                end else if (last) begin
                    state_n = S_ENCRYPT;
                    sel_n   = CIPHER;
                end else begin
                    addr_n = addr + ONE;
                end
            end
            S_ENCRYPT, S_COPY: begin
                if (abort) begin
                    state_n = S_WAIT;
                end else if (last) begin
                    state_n = S_WAIT;
                    done_n  = 1'b1;
                end else begin
                    addr_n = addr + ONE;
                end
            end
            S_WAIT: begin
                if (crypt_rise) begin
                    state_n = S_CLEAR;
                end else if (btn_valid) begin
                    state_n = S_COPY;
                    sel_n   = btn_idx;
                end
            end
            default: begin
                state_n = S_INIT;
            end
        endcase
    end

    // Output decode of the upcoming state, so the flops track the state.
    always_comb begin
        we_n   = 1'b0;
        clr_n  = 1'b0;
        enc_n  = 1'b0;
        cop_n  = 1'b0;
        busy_n = 1'b0;
        init_n = 1'b0;
        wait_n = 1'b0;
        unique case (1'b1)
            state_n == S_CLEAR: begin
                we_n   = 1'b1;
                clr_n  = 1'b1;
                busy_n = 1'b1;
            end
            state_n == S_ENCRYPT: begin
                we_n   = 1'b1;
                enc_n  = 1'b1;
                cop_n  = 1'b1;
                busy_n = 1'b1;
            end
            state_n == S_COPY: begin
                we_n   = 1'b1;
                cop_n  = 1'b1;
                busy_n = 1'b1;
            end
            state_n == S_WAIT: begin
                wait_n = 1'b1;
            end
            default: begin
                init_n = 1'b1;
            end
        endcase
    end

    // Input edge registers, sampled every cycle even while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crypt_q <= 1'b0;
            btn_q   <= '0;
        end else begin
            crypt_q <= crypt;
            btn_q   <= btn;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_INIT;
            addr          <= '0;
            src_sel       <= '0;
            done          <= 1'b0;
            ram_we        <= 1'b0;
            clr_ram       <= 1'b0;
            en_encryption <= 1'b0;
            en_copier     <= 1'b0;
            busy          <= 1'b0;
            led_init      <= 1'b1;
            led_wait      <= 1'b0;
        end else begin
            state         <= state_n;
            addr          <= addr_n;
            src_sel       <= sel_n;
            done          <= done_n;
            ram_we        <= we_n;
            clr_ram       <= clr_n;
            en_encryption <= enc_n;
            en_copier     <= cop_n;
            busy          <= busy_n;
            led_init      <= init_n;
            led_wait      <= wait_n;
        end
    end

endmodule

// File: doc/xor_cipher_sequencer.md
Name: xor_cipher_sequencer

Overview:
- Parametrised second-generation controller for the XOR cipher datapath. It sequences RAM clear, encryption and copy-out of one of N_SRC buffers (text, key, cipher, ...) to the display/output RAM.
- Unlike the first-generation controller, it owns the RAM address counter, so no external completion strobes are needed. It also edge-detects its command inputs, supports abort, and reports busy/done status.
- Sits between the board buttons and the cipher engine, copier and RAMs.

Parameters:
ADDR_W, 5, RAM address width
DEPTH, 32, words processed per pass; legal range 1..2**ADDR_W
N_SRC, 3, number of selectable copy sources (>=2)
SEL_W, 2, width of src_sel; must satisfy 2**SEL_W >= N_SRC

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
crypt  in  1  start-encryption request, level input, rising-edge triggered
btn  in  N_SRC  copy-source request buttons, rising-edge triggered; bit i selects source i
abort  in  1  synchronous abort of the running pass, level
addr  out  ADDR_W  RAM address for the current pass
ram_we  out  1  write enable for the destination RAM
clr_ram  out  1  high while the clear pass writes zeros
en_encryption  out  1  cipher engine enable
en_copier  out  1  copier enable
src_sel  out  SEL_W  source index for copier/encryption read mux
busy  out  1  high in CLEAR, ENCRYPT, COPY
done  out  1  one-cycle pulse when a pass completes normally
led_init  out  1  high in INIT
led_wait  out  1  high in WAIT

Behaviour:
- Reset (async assert, sync release): state=INIT, addr=0, all outputs 0 except led_init=1, src_sel=0, edge registers cleared.
- Edge detect: crypt_q and btn_q registers sample the inputs every cycle. A request is input & ~input_q. A held button fires once only; it must be released for at least one cycle before it can fire again.
- Button request is valid only when exactly one btn rise occurs in a cycle. Multiple simultaneous rises are ignored.
- All outputs are registered, decoded from the state and counter.

States:
- INIT: led_init=1. A crypt rise moves to CLEAR.
- CLEAR: clr_ram=1, ram_we=1, busy=1. addr counts 0..DEPTH-1, one per cycle. After writing DEPTH-1, go to ENCRYPT with addr reset to 0. No done pulse.
- ENCRYPT: en_encryption=1, en_copier=1, ram_we=1, busy=1, src_sel=N_SRC-1 (cipher buffer). addr counts 0..DEPTH-1. After DEPTH-1, go to WAIT; done=1 for the cycle WAIT is entered.
- WAIT: led_wait=1. A valid btn[i] rise latches src_sel=i and goes to COPY with addr=0. A crypt rise goes to CLEAR (re-encrypt). If both occur in the same cycle, crypt wins.
- COPY: en_copier=1, ram_we=1, busy=1, src_sel held. addr counts 0..DEPTH-1, then go to WAIT with done pulse.
- Requests arriving while busy are dropped; they are not queued.

Boundaries:
- abort high in CLEAR/ENCRYPT/COPY: next state is WAIT, addr=0, ram_we=0, no done pulse. Exception: abort in CLEAR goes to INIT, because RAM contents are indeterminate.
- abort in INIT/WAIT has no effect.
- DEPTH=1: each pass lasts exactly one cycle.
- addr never exceeds DEPTH-1. Terminal count is compared with DEPTH-1 at ADDR_W width.
- Illegal state encodings recover to INIT next cycle with all enables 0.
- Reset mid-pass aborts immediately and asynchronously; outputs return to reset values.

Test Plan:
- Reset, then crypt rise at cycle 10 (DEPTH=32) -> CLEAR for cycles 11-42 with addr 0..31 and clr_ram=1; ENCRYPT for 43-74 with en_encryption=1 and src_sel=2; done=1 exactly at cycle 75; led_wait=1 from 75.
- In WAIT, btn=3'b010 held for 50 cycles -> one COPY pass with src_sel=1, addr 0..31, single done pulse; no second pass until btn is released and pressed again.
- In WAIT, btn=3'b101 rising in one cycle -> no state change, led_wait stays 1; same cycle with crypt rise and btn=3'b001 -> CLEAR entered, src_sel unchanged.
- abort asserted when addr=7 in COPY -> WAIT next cycle, addr=0, ram_we=0, done=0; abort at addr=5 in CLEAR -> INIT, led_init=1.
- reset driven low asynchronously at addr=20 in ENCRYPT -> outputs at reset values before the next clk edge; after release, crypt rise restarts from CLEAR at addr=0.
- Parameter sweep DEPTH=1, N_SRC=4, SEL_W=2 -> single-cycle passes, btn[3] gives src_sel=3, done pulse each pass.
